// File: rtl/saber_swing_detector_if.sv
// Bus bundle for saber_swing_detector: tick time, live and delayed tip
// positions for both hands (inputs to the detector) and the per-hand swing
// results plus busy (outputs of the detector).
interface saber_swing_detector_if;
  logic [17:0] curr_time;
  logic [11:0] hand_x_left_top;
  logic [11:0] hand_y_left_top;
  logic [13:0] hand_z_left_top;
  logic [11:0] hand_x_right_top;
  logic [11:0] hand_y_right_top;
  logic [13:0] hand_z_right_top;
  logic [11:0] prev_hand_x_left_top;
  logic [11:0] prev_hand_y_left_top;
  logic [13:0] prev_hand_z_left_top;
  logic [11:0] prev_hand_x_right_top;
  logic [11:0] prev_hand_y_right_top;
  logic [13:0] prev_hand_z_right_top;
  logic        swing_left;
  logic        swing_right;
  logic [1:0]  swing_dir_left;
  logic [1:0]  swing_dir_right;
  logic [14:0] swing_speed_left;
  logic [14:0] swing_speed_right;
  logic        busy;

  modport master (
    output curr_time,
    output hand_x_left_top, hand_y_left_top, hand_z_left_top,
    output hand_x_right_top, hand_y_right_top, hand_z_right_top,
    output prev_hand_x_left_top, prev_hand_y_left_top, prev_hand_z_left_top,
    output prev_hand_x_right_top, prev_hand_y_right_top, prev_hand_z_right_top,
    input  swing_left, swing_right, swing_dir_left, swing_dir_right,
    input  swing_speed_left, swing_speed_right, busy
  );

  modport slave (
    input  curr_time,
    input  hand_x_left_top, hand_y_left_top, hand_z_left_top,
    input  hand_x_right_top, hand_y_right_top, hand_z_right_top,
    input  prev_hand_x_left_top, prev_hand_y_left_top, prev_hand_z_left_top,
    input  prev_hand_x_right_top, prev_hand_y_right_top, prev_hand_z_right_top,
    output swing_left, swing_right, swing_dir_left, swing_dir_right,
    output swing_speed_left, swing_speed_right, busy
  );
endinterface

// File: rtl/saber_swing_detector.sv
// saber_swing_detector: once per game-time tick, computes per-hand tip
// displacement, Manhattan speed and 4-way direction on one shared datapath
// (left hand, then right hand) and emits a one-cycle swing pulse per hand.
// Optional feature macro: SWING_Z_EN adds |dz| to the speed.
module saber_swing_detector #(
  parameter int unsigned SPEED_THRESH   = 64,
  parameter int unsigned COOLDOWN_TICKS = 4,
  parameter int unsigned WARMUP_TICKS   = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  saber_swing_detector_if.slave   bus
);

  localparam logic [14:0] THRESH   = 15'(SPEED_THRESH);
  localparam logic [7:0]  CD_LOAD  = 8'(COOLDOWN_TICKS);
  localparam logic [7:0]  WARM_MAX = 8'(WARMUP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT, S_PUBLISH} state_t;

  state_t      state, state_n;
  logic [17:0] last_time;
  logic        tick;

  logic [11:0] cx_l, cy_l, px_l, py_l, cx_r, cy_r, px_r, py_r;
  logic [11:0] m_cx, m_cy, m_px, m_py;
  logic signed [12:0] dx, dy;
  logic [12:0] adx, ady;
  logic [14:0] spd;
  logic [1:0]  dir;
`ifdef SWING_Z_EN
  logic [13:0] cz_l, pz_l, cz_r, pz_r;
  logic [13:0] m_cz, m_pz;
  logic signed [14:0] dz;
  logic [14:0] adz;
`endif

  logic [14:0] spd_l_q;
  logic [1:0]  dir_l_q;
  logic [7:0]  warm, cd_l, cd_r;
  logic        warm_done, sw_l, sw_r;

  // A tick is only recognised in IDLE, so changes while busy are deferred
  // and coalesce into a single tick against last_time.
  assign tick     = (state == S_IDLE) && (bus.curr_time != last_time);
  assign bus.busy = (state != S_IDLE);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_n;
  end

  // Next-state: fixed IDLE -> LEFT -> RIGHT -> PUBLISH sequence per tick
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (tick) state_n = S_LEFT;
      S_LEFT:    state_n = S_RIGHT;
      S_RIGHT:   state_n = S_PUBLISH;
      S_PUBLISH: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Capture all positions and the tick time when a tick is accepted
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_time <= '0;
      cx_l <= '0; cy_l <= '0; px_l <= '0; py_l <= '0;
      cx_r <= '0; cy_r <= '0; px_r <= '0; py_r <= '0;
`ifdef SWING_Z_EN
      cz_l <= '0; pz_l <= '0; cz_r <= '0; pz_r <= '0;
`endif
    end else if (tick) begin
      last_time <= bus.curr_time;
      cx_l <= bus.hand_x_left_top;       cy_l <= bus.hand_y_left_top;
      px_l <= bus.prev_hand_x_left_top;  py_l <= bus.prev_hand_y_left_top;
      cx_r <= bus.hand_x_right_top;      cy_r <= bus.hand_y_right_top;
      px_r <= bus.prev_hand_x_right_top; py_r <= bus.prev_hand_y_right_top;
`ifdef SWING_Z_EN
      cz_l <= bus.hand_z_left_top;       pz_l <= bus.prev_hand_z_left_top;
      cz_r <= bus.hand_z_right_top;      pz_r <= bus.prev_hand_z_right_top;
`endif
    end
  end

  // Shared datapath: left-hand operands except in RIGHT state
  always_comb begin
    m_cx = (state == S_RIGHT) ? cx_r : cx_l;
    m_cy = (state == S_RIGHT) ? cy_r : cy_l;
    m_px = (state == S_RIGHT) ? px_r : px_l;
    m_py = (state == S_RIGHT) ? py_r : py_l;
    dx   = $signed({1'b0, m_cx}) - $signed({1'b0, m_px});
    dy   = $signed({1'b0, m_cy}) - $signed({1'b0, m_py});
    adx  = dx[12] ? -dx : dx;
    ady  = dy[12] ? -dy : dy;
    spd  = {2'b00, adx} + {2'b00, ady};
`ifdef SWING_Z_EN
    m_cz = (state == S_RIGHT) ? cz_r : cz_l;
    m_pz = (state == S_RIGHT) ? pz_r : pz_l;
    dz   = $signed({1'b0, m_cz}) - $signed({1'b0, m_pz});
    adz  = dz[14] ? -dz : dz;
    spd  = spd + adz;
`endif
    // Ties go horizontal; within vertical, ady > adx guarantees dy != 0
    if (adx >= ady) dir = dx[12] ? 2'b10 : 2'b11;
    else            dir = dy[12] ? 2'b00 : 2'b01;
  end

  // Swing qualification uses pre-update warmup and cooldown values
  always_comb begin
    warm_done = (warm >= WARM_MAX);
    sw_l      = warm_done && (spd_l_q >= THRESH) && (cd_l == '0);
    sw_r      = warm_done && (spd >= THRESH) && (cd_r == '0);
  end

  // Results are registered on the edge into PUBLISH so the pulse, speed and
  // direction are all visible during the PUBLISH cycle itself.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      spd_l_q               <= '0;
      dir_l_q               <= '0;
      warm                  <= '0;
      cd_l                  <= '0;
      cd_r                  <= '0;
      bus.swing_left        <= 1'b0;
      bus.swing_right       <= 1'b0;
      bus.swing_dir_left    <= '0;
      bus.swing_dir_right   <= '0;
      bus.swing_speed_left  <= '0;
      bus.swing_speed_right <= '0;
    end else begin
      bus.swing_left  <= 1'b0;
      bus.swing_right <= 1'b0;
      if (state == S_LEFT) begin
        spd_l_q <= spd;
        dir_l_q <= dir;
      end else if (state == S_RIGHT) begin
        bus.swing_speed_left  <= spd_l_q;
        bus.swing_dir_left    <= dir_l_q;
        bus.swing_speed_right <= spd;
        bus.swing_dir_right   <= dir;
        bus.swing_left        <= sw_l;
        bus.swing_right       <= sw_r;
        cd_l <= sw_l ? CD_LOAD : ((cd_l != '0) ? cd_l - 8'd1 : cd_l);
        cd_r <= sw_r ? CD_LOAD : ((cd_r != '0) ? cd_r - 8'd1 : cd_r);
        if (!warm_done) warm <= warm + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_saber_swing_detector.sv
// Testbench for saber_swing_detector: directed table, multi-cycle corner
// sequences and randomized ticks checked against a behavioural model.
module tb_saber_swing_detector;

  localparam int THRESH = 64;
  localparam int CD     = 4;
  localparam int WARM   = 2;

  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  saber_swing_detector_if bus();

  saber_swing_detector #(
    .SPEED_THRESH(THRESH), .COOLDOWN_TICKS(CD), .WARMUP_TICKS(WARM)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int m_warm, m_cd_l, m_cd_r;

  typedef struct {
    string    nm;
    int       dxl, dyl, dzl, dxr, dyr, dzr;
    bit       swl, swr;
    bit [1:0] dirl, dirr;
    int       spdl, spdr;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_swl"},  int'(bus.swing_left), 0);
    chk({nm, "_swr"},  int'(bus.swing_right), 0);
    chk({nm, "_dirl"}, int'(bus.swing_dir_left), 0);
    chk({nm, "_dirr"}, int'(bus.swing_dir_right), 0);
    chk({nm, "_spdl"}, int'(bus.swing_speed_left), 0);
    chk({nm, "_spdr"}, int'(bus.swing_speed_right), 0);
    chk({nm, "_busy"}, int'(bus.busy), 0);
  endtask

  task automatic set_raw(input bit rh, input int xc, input int xp, input int yc,
                         input int yp, input int zc, input int zp);
    if (rh) begin
      bus.hand_x_right_top = 12'(xc); bus.prev_hand_x_right_top = 12'(xp);
      bus.hand_y_right_top = 12'(yc); bus.prev_hand_y_right_top = 12'(yp);
      bus.hand_z_right_top = 14'(zc); bus.prev_hand_z_right_top = 14'(zp);
    end else begin
      bus.hand_x_left_top = 12'(xc); bus.prev_hand_x_left_top = 12'(xp);
      bus.hand_y_left_top = 12'(yc); bus.prev_hand_y_left_top = 12'(yp);
      bus.hand_z_left_top = 14'(zc); bus.prev_hand_z_left_top = 14'(zp);
    end
  endtask

  // Place a displacement d in the middle of the coordinate range
  function automatic void split(input int d, input int full, output int c, output int p);
    if (d >= 0) begin p = (full - d) / 2; c = p + d; end
    else        begin c = (full + d) / 2; p = c - d; end
  endfunction

  task automatic set_hand(input bit rh, input int dx, input int dy, input int dz);
    int xc, xp, yc, yp, zc, zp;
    split(dx, 4095, xc, xp);
    split(dy, 4095, yc, yp);
    split(dz, 16383, zc, zp);
    set_raw(rh, xc, xp, yc, yp, zc, zp);
  endtask

  task automatic reset_dut();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    bus.curr_time = '0;
    set_hand(1'b0, 0, 0, 0);
    set_hand(1'b1, 0, 0, 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    m_warm = 0; m_cd_l = 0; m_cd_r = 0;
  endtask

  // One tick: capture at the next edge, pulse in the third cycle after it
  task automatic do_tick(input string nm, input bit esl, input bit esr,
                         input bit [1:0] edl, input bit [1:0] edr,
                         input int espl, input int espr);
    @(negedge clk_in);
    bus.curr_time = bus.curr_time + 18'd1;
    @(negedge clk_in);
    chk({nm, "_busy_c1"}, int'(bus.busy), 1);
    chk({nm, "_pulse_c1"}, int'({bus.swing_left, bus.swing_right}), 0);
    @(negedge clk_in);
    chk({nm, "_busy_c2"}, int'(bus.busy), 1);
    chk({nm, "_pulse_c2"}, int'({bus.swing_left, bus.swing_right}), 0);
    @(negedge clk_in);
    chk({nm, "_busy_c3"}, int'(bus.busy), 1);
    chk({nm, "_swl"},  int'(bus.swing_left), int'(esl));
    chk({nm, "_swr"},  int'(bus.swing_right), int'(esr));
    chk({nm, "_dirl"}, int'(bus.swing_dir_left), int'(edl));
    chk({nm, "_dirr"}, int'(bus.swing_dir_right), int'(edr));
    chk({nm, "_spdl"}, int'(bus.swing_speed_left), espl);
    chk({nm, "_spdr"}, int'(bus.swing_speed_right), espr);
    @(negedge clk_in);
    chk({nm, "_busy_c4"}, int'(bus.busy), 0);
    chk({nm, "_pulse_c4"}, int'({bus.swing_left, bus.swing_right}), 0);
    chk({nm, "_hold_spdl"}, int'(bus.swing_speed_left), espl);
    chk({nm, "_hold_spdr"}, int'(bus.swing_speed_right), espr);
  endtask

  // Reference: speed and direction straight from the displacement rules
  function automatic void hand_eval(input int dx, input int dy, input int dz,
                                    output int spd, output bit [1:0] dir);
    int ax, ay;
    ax  = (dx < 0) ? -dx : dx;
    ay  = (dy < 0) ? -dy : dy;
    spd = ax + ay;
`ifdef SWING_Z_EN
    spd = spd + ((dz < 0) ? -dz : dz);
`endif
    if (ax >= ay) dir = (dx >= 0) ? 2'b11 : 2'b10;
    else          dir = (dy > 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic int rnd_near(input int c, input int full);
    int p;
    if ($urandom_range(0, 1) == 1) p = int'($urandom_range(0, full));
    else p = c + int'($urandom_range(0, 160)) - 80;
    if (p < 0) p = 0;
    if (p > full) p = full;
    return p;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_busy[9];
    rst_n_in = 1'b0;

    tbl[0]  = '{"x_pos",    100,    0, 0,     0,    0,   0, 1, 0, 2'b11, 2'b11, 100, 0};
    tbl[1]  = '{"y_up",       0, -100, 0,     0,    0,   0, 1, 0, 2'b00, 2'b11, 100, 0};
    tbl[2]  = '{"y_down",     0,  100, 0,     0,    0,   0, 1, 0, 2'b01, 2'b11, 100, 0};
    tbl[3]  = '{"spd63",     40,  -23, 0,     0,    0,   0, 0, 0, 2'b11, 2'b11, 63, 0};
    tbl[4]  = '{"spd64",     40,  -24, 0,     0,    0,   0, 1, 0, 2'b11, 2'b11, 64, 0};
    tbl[5]  = '{"tie_neg",  -30,   30, 0,     0,    0,   0, 0, 0, 2'b10, 2'b11, 60, 0};
    tbl[6]  = '{"right500",   0,    0, 0,   300, -200,   0, 0, 1, 2'b11, 2'b11, 0, 500};
    tbl[7]  = '{"both_max",   5,   70, 0, -4095, 4095,   0, 1, 1, 2'b01, 2'b10, 75, 8190};
    tbl[8]  = '{"x_neg",   -100,   50, 0,     0,    0,   0, 1, 0, 2'b10, 2'b11, 150, 0};
    tbl[9]  = '{"up_steep",  10,  -63, 0,     0,    0,   0, 1, 0, 2'b00, 2'b11, 73, 0};
`ifdef SWING_Z_EN
    tbl[10] = '{"z_only",     0,    0, 1000,  0,    0,   0, 1, 0, 2'b11, 2'b11, 1000, 0};
    tbl[11] = '{"z_mix",      0,    0, 0,    10,  -20, -50, 0, 1, 2'b11, 2'b00, 0, 80};
`else
    tbl[10] = '{"z_only",     0,    0, 1000,  0,    0,   0, 0, 0, 2'b11, 2'b11, 0, 0};
    tbl[11] = '{"z_mix",      0,    0, 0,    10,  -20, -50, 0, 0, 2'b11, 2'b00, 0, 30};
`endif

    // Reset state, then three ticks with left x 500 -> 600
    reset_dut();
    chk_zero("reset");
    bus.hand_x_left_top = 12'd600;
    bus.prev_hand_x_left_top = 12'd500;
    do_tick("t1_tick1", 0, 0, 2'b11, 2'b11, 100, 0);
    do_tick("t1_tick2", 0, 0, 2'b11, 2'b11, 100, 0);
    do_tick("t1_tick3", 1, 0, 2'b11, 2'b11, 100, 0);

    // Table: each row runs on a freshly warmed-up detector
    for (int i = 0; i < 12; i++) begin
      reset_dut();
      do_tick({tbl[i].nm, "_w1"}, 0, 0, 2'b11, 2'b11, 0, 0);
      do_tick({tbl[i].nm, "_w2"}, 0, 0, 2'b11, 2'b11, 0, 0);
      set_hand(1'b0, tbl[i].dxl, tbl[i].dyl, tbl[i].dzl);
      set_hand(1'b1, tbl[i].dxr, tbl[i].dyr, tbl[i].dzr);
      do_tick(tbl[i].nm, tbl[i].swl, tbl[i].swr, tbl[i].dirl, tbl[i].dirr,
              tbl[i].spdl, tbl[i].spdr);
    end

    // Cooldown: right speed 500 on six consecutive ticks
    reset_dut();
    do_tick("t4_w1", 0, 0, 2'b11, 2'b11, 0, 0);
    do_tick("t4_w2", 0, 0, 2'b11, 2'b11, 0, 0);
    set_hand(1'b1, 300, -200, 0);
    for (int k = 1; k <= 6; k++)
      do_tick($sformatf("t4_tick%0d", k), 0, (k == 1 || k == 6), 2'b11, 2'b11, 0, 500);

    // Time changes on two cycles while busy: one deferred tick only
    reset_dut();
    exp_busy = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
    @(negedge clk_in);
    bus.curr_time = bus.curr_time + 18'd1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_in);
      chk($sformatf("t5_busy%0d", k), int'(bus.busy), exp_busy[k]);
      if (k < 2) bus.curr_time = bus.curr_time + 18'd1;
    end

    // Reset asserted in the RIGHT state of a tick that would have pulsed
    reset_dut();
    set_hand(1'b0, 100, 0, 0);
    do_tick("t6_w1", 0, 0, 2'b11, 2'b11, 100, 0);
    do_tick("t6_w2", 0, 0, 2'b11, 2'b11, 100, 0);
    @(negedge clk_in);
    bus.curr_time = bus.curr_time + 18'd1;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("t6_in_flight_busy", int'(bus.busy), 1);
    rst_n_in = 1'b0;
    #1;
    chk_zero("t6_async");
    bus.curr_time = '0;
    repeat (2) begin
      @(negedge clk_in);
      chk("t6_no_pulse_in_reset", int'(bus.swing_left), 0);
    end
    rst_n_in = 1'b1;
    do_tick("t6_after1", 0, 0, 2'b11, 2'b11, 100, 0);
    do_tick("t6_after2", 0, 0, 2'b11, 2'b11, 100, 0);
    do_tick("t6_after3", 1, 0, 2'b11, 2'b11, 100, 0);

    // Randomized ticks against the reference model
    reset_dut();
    for (int i = 0; i < 150; i++) begin
      int xc[2], xp[2], yc[2], yp[2], zc[2], zp[2];
      int sp[2];
      bit [1:0] dr[2];
      bit sw[2];
      bit warm_ok;
      for (int h = 0; h < 2; h++) begin
        xc[h] = int'($urandom_range(0, 4095));  xp[h] = rnd_near(xc[h], 4095);
        yc[h] = int'($urandom_range(0, 4095));  yp[h] = rnd_near(yc[h], 4095);
        zc[h] = int'($urandom_range(0, 16383)); zp[h] = rnd_near(zc[h], 16383);
        set_raw(h == 1, xc[h], xp[h], yc[h], yp[h], zc[h], zp[h]);
        hand_eval(xc[h] - xp[h], yc[h] - yp[h], zc[h] - zp[h], sp[h], dr[h]);
      end
      warm_ok = (m_warm >= WARM);
      sw[0] = warm_ok && (sp[0] >= THRESH) && (m_cd_l == 0);
      sw[1] = warm_ok && (sp[1] >= THRESH) && (m_cd_r == 0);
      if (sw[0]) m_cd_l = CD; else if (m_cd_l > 0) m_cd_l--;
      if (sw[1]) m_cd_r = CD; else if (m_cd_r > 0) m_cd_r--;
      if (m_warm < WARM) m_warm++;
      do_tick($sformatf("rnd%0d", i), sw[0], sw[1], dr[0], dr[1], sp[0], sp[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
